// File: rtl/dm_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus types, register map,
// register bit positions and FSM state encoding.
package dm_uart_tx_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h8;

    localparam int unsigned STATUS_BUSY    = 0;
    localparam int unsigned STATUS_FULL    = 1;
    localparam int unsigned STATUS_EMPTY   = 2;
    localparam int unsigned STATUS_OVF     = 3;
    localparam int unsigned STATUS_CNT_LSB = 4;

    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    typedef logic [1:0] uart_tx_state_t;

    localparam uart_tx_state_t ST_IDLE  = 2'd0;
    localparam uart_tx_state_t ST_START = 2'd1;
    localparam uart_tx_state_t ST_DATA  = 2'd2;
    localparam uart_tx_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/dm_uart_tx_fifo.sv
// Byte-wide synchronous TX FIFO with first-word-fall-through read data.
// Pushes while full are dropped; the caller is responsible for flagging overflow.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [7:0]             i_wdata,
    input  logic                   i_pop,
    output logic [7:0]             o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rptr_q];

    // Full is judged on the registered count, so a push never sneaks in beside a pop.
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dm_uart_tx.sv
// Data-memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL registers in a 16-byte window,
// an 8-entry TX FIFO and a frame serialiser whose line output comes straight from a flop.
module dm_uart_tx
    import dm_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  addr_t      i_DM_addr,
    input  data_t      i_DM_wd,
    input  logic [3:0] i_DM_wen,
    input  logic       i_DM_ren,
    output data_t      o_DM_rd,
    output logic       o_uart_tx,
    output logic       o_irq
);

    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [2:0]     bit_nxt;
    logic [7:0]     data_q, data_d;
    logic           tx_q, tx_d;
    logic           tx_en_q;
    logic           irq_en_q;
    logic           ovf_q;

    logic           hit;
    logic [3:0]     offs;
    logic           wr_lane0;
    logic           push;
    logic           ovf_clr;
    logic           ctrl_we;
    logic           busy;
    logic           baud_end;
    logic           fifo_pop;
    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    data_t          status_word;
    data_t          ctrl_word;
    logic           unused_bits;

    assign hit      = (i_DM_addr[31:4] == BASE_ADDR[31:4]);
    assign offs     = i_DM_addr[3:0];
    assign wr_lane0 = hit & i_DM_wen[0];
    assign push     = wr_lane0 && (offs == UART_TXDATA);
    assign ovf_clr  = wr_lane0 && (offs == UART_STATUS) && i_DM_wd[STATUS_OVF];
    assign ctrl_we  = wr_lane0 && (offs == UART_CTRL);
    assign unused_bits = ^{i_DM_wd[31:8], i_DM_wen[3:1]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata (i_DM_wd[7:0]),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign busy      = (state_q != ST_IDLE);
    assign baud_end  = (baud_q == BAUD_MAX);
    assign bit_nxt   = bit_q + 3'd1;
    assign o_uart_tx = tx_q;
    assign o_irq     = irq_en_q & fifo_empty & ~busy;

    always_comb begin
        status_word                             = '0;
        status_word[STATUS_BUSY]                = busy;
        status_word[STATUS_FULL]                = fifo_full;
        status_word[STATUS_EMPTY]               = fifo_empty;
        status_word[STATUS_OVF]                 = ovf_q;
        status_word[STATUS_CNT_LSB +: 4]        = 4'(fifo_count);
        ctrl_word                               = '0;
        ctrl_word[CTRL_TX_EN]                   = tx_en_q;
        ctrl_word[CTRL_IRQ_EN]                  = irq_en_q;
    end

    always_comb begin
        o_DM_rd = '0;
        if (i_DM_ren && hit) begin
            case (offs)
                UART_STATUS: o_DM_rd = status_word;
                UART_CTRL:   o_DM_rd = ctrl_word;
                default:     o_DM_rd = '0;
            endcase
        end
    end

    // STOP may chain directly into the next START so back-to-back frames have no idle gap.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_en_q && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rdata;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (tx_en_q && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        data_d   = fifo_rdata;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            tx_q     <= 1'b1;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            if (push && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (ctrl_we) begin
                tx_en_q  <= i_DM_wd[CTRL_TX_EN];
                irq_en_q <= i_DM_wd[CTRL_IRQ_EN];
            end
        end
    end

endmodule

// File: tb/tb_dm_uart_tx.sv
// Scoreboard bench for dm_uart_tx: stimulus queues expected bytes, a line monitor decodes
// 8N1 frames and checks them; register reads are checked against an arithmetic model.
module tb_dm_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  wen;
    logic        ren;
    logic [31:0] rd;
    logic        tx;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          wr_cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    bit          in_frame = 1'b0;

    dm_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_DM_addr (addr),
        .i_DM_wd   (wd),
        .i_DM_wen  (wen),
        .i_DM_ren  (ren),
        .o_DM_rd   (rd),
        .o_uart_tx (tx),
        .o_irq     (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        @(posedge clk);
        #1;
        addr = a;
        wd   = d;
        wen  = we;
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        addr   = '0;
        wd     = '0;
        wen    = '0;
    endtask

    // Combinational read; caller keeps it clear of a clock edge.
    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        ren  = 1'b1;
        #1;
        check(name, rd, exp);
        ren  = 1'b0;
        addr = '0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(BASE, {24'h0, b}, 4'b0001);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(n < 4000), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic       prev;
        logic [7:0] eb;
        logic [7:0] got;
        logic       exp_bit;
        bit         bad;
        bit         aborted;
        bit         has_exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !tx) begin
                in_frame = 1'b1;
                start_q.push_back(cyc);
                has_exp = (exp_q.size() != 0);
                if (has_exp) eb = exp_q.pop_front();
                else         eb = 8'h00;
                got     = '0;
                bad     = 1'b0;
                aborted = 1'b0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c != 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c < DIV)            exp_bit = 1'b0;
                    else if (c >= 9 * DIV)  exp_bit = 1'b1;
                    else                    exp_bit = eb[(c - DIV) / DIV];
                    if (tx !== exp_bit) bad = 1'b1;
                    if (c >= DIV && c < 9 * DIV && (c % DIV) == DIV / 2)
                        got[(c - DIV) / DIV] = tx;
                end
                in_frame = 1'b0;
                if (!aborted) begin
                    check("frame_expected", 32'(has_exp), 32'd1);
                    if (has_exp) begin
                        check("frame_data", {24'h0, got}, {24'h0, eb});
                        check("frame_shape", 32'(bad), 32'd0);
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        int          s0;
        int          s1;
        int          n_wr;
        int          n_acc;
        int          cnt;
        logic [7:0]  b;
        logic [31:0] exp_st;

        rst  = 1'b1;
        addr = '0;
        wd   = '0;
        wen  = '0;
        ren  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        check_reg("reset_status", BASE + 32'h4, 32'h0000_0004);
        check_reg("reset_ctrl", BASE + 32'h8, 32'h0000_0001);

        // Single frame and start latency.
        start_q.delete();
        push_byte(8'hA5);
        wait_drain();
        s0 = (start_q.size() >= 1) ? start_q[0] : -1;
        check("start_latency", 32'(s0), 32'(wr_cyc + 1));
        check_reg("status_after_a5", BASE + 32'h4, 32'h0000_0004);

        // Back-to-back frames: next START immediately after STOP.
        start_q.delete();
        push_byte(8'h55);
        push_byte(8'h0F);
        wait_drain();
        s0 = (start_q.size() >= 2) ? start_q[0] : -1;
        s1 = (start_q.size() >= 2) ? start_q[1] : -1000;
        check("b2b_gap", 32'(s1 - s0), 32'(FRAME));

        // Randomized fill with tx disabled, overflow and lane masking, then drain.
        for (int it = 0; it < 6; it++) begin
            bus_write(BASE + 32'h8, 32'h0, 4'b0001);
            check_reg("ctrl_off", BASE + 32'h8, 32'h0);
            n_wr  = (it == 0) ? 9 : int'($urandom_range(1, 12));
            n_acc = 0;
            for (int i = 0; i < n_wr; i++) begin
                b = 8'($urandom);
                if (it != 0 && $urandom_range(0, 3) == 0) begin
                    bus_write(BASE, {24'($urandom), b}, 4'($urandom_range(1, 7) << 1));
                end else begin
                    if (n_acc < 8) exp_q.push_back(b);
                    n_acc++;
                    bus_write(BASE, {24'($urandom), b}, 4'b0001 | 4'($urandom_range(0, 7) << 1));
                end
            end
            cnt    = (n_acc > 8) ? 8 : n_acc;
            exp_st = (32'(cnt) << 4) | (32'(n_acc > 8) << 3) | (32'(cnt == 0) << 2)
                     | (32'(cnt == 8) << 1);
            check_reg("fill_status", BASE + 32'h4, exp_st);
            if (n_acc > 8) begin
                bus_write(BASE + 32'h4, 32'h8, 4'b0001);
                check_reg("ovf_clear", BASE + 32'h4, exp_st & ~32'h8);
            end
            bus_write(BASE + 32'h8, 32'h1, 4'b0001);
            wait_drain();
            check_reg("drained_status", BASE + 32'h4, 32'h0000_0004);
        end

        // Interrupt: level while idle+empty, dropped by a push, back after STOP.
        bus_write(BASE + 32'h8, 32'h3, 4'b0001);
        check("irq_idle", 32'(irq), 32'd1);
        push_byte(8'h3C);
        check("irq_push_drop", 32'(irq), 32'd0);
        repeat (FRAME) @(posedge clk);
        #1;
        check("irq_in_stop", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        check("irq_rise", 32'(irq), 32'd1);
        push_byte(8'h96);
        check("irq_second_drop", 32'(irq), 32'd0);
        wait_drain();
        bus_write(BASE + 32'h8, 32'h1, 4'b0001);

        // Decode misses, unmapped offsets and strobe gating.
        check_reg("miss_read", BASE + 32'h20, 32'h0);
        check_reg("txdata_read", BASE, 32'h0);
        check_reg("offs_c_read", BASE + 32'hC, 32'h0);
        addr = BASE + 32'h4;
        ren  = 1'b0;
        #1;
        check("no_ren_read", rd, 32'h0);
        bus_write(BASE + 32'h20, 32'hFF, 4'hF);
        check_reg("miss_write", BASE + 32'h4, 32'h0000_0004);

        // Reset in the middle of the data bits.
        push_byte(8'hC3);
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(dut.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("reset_mid_tx", 32'(tx), 32'd1);
        check_reg("reset_mid_status", BASE + 32'h4, 32'h0000_0004);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (FRAME) @(posedge clk);
        #1;
        check("post_reset_line", 32'(tx), 32'd1);
        check_reg("post_reset_status", BASE + 32'h4, 32'h0000_0004);
        check("leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
